// File: rtl/bp_pkg.sv
// Shared types for the branch-history-table update controller.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package bp_pkg;

  // Widest counter-table index an in-flight entry can carry; s_index must stay below it.
  localparam int unsigned BP_IDX_W = 16;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_t;

  typedef struct packed {
    logic [BP_IDX_W-1:0] index;
    logic                pred;
  } bp_entry_t;

  function automatic bp_entry_t bp_make_entry(input logic [BP_IDX_W-1:0] index,
                                              input logic                pred);
    bp_entry_t e;
    e.index = index;
    e.pred  = pred;
    return e;
  endfunction

endpackage

// File: rtl/bp_fifo.sv
// Synchronous FIFO with flush, head word visible combinationally on rdat.
// Latency: push visible at rdat one cycle later; pop takes effect at the next edge.
// Backpressure: push ignored when full, pop ignored when empty, flush drops both.
module bp_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned depth = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [W-1:0]            wdat,
  output logic [W-1:0]            rdat,
  output logic [$clog2(depth):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [W-1:0]  mem [depth];
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(depth));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdat    = mem[head];

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + AW'(1);
      if (do_pop)  head <= head + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone says which words are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= wdat;
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// Branch-history-table update controller: clears the counter table, tracks in-flight predictions, trains on resolution.
// Latency: prediction combinational from ctr_out; counter update/mispredict/res_error one cycle after resolution.
// Backpressure: pred_ready low during the init sweep and while depth predictions are in flight.
module bht_update_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned s_index  = 3,
  parameter int unsigned num_sets = 2**s_index,
  parameter int unsigned depth    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pred_valid,
  input  logic [s_index-1:0]      pred_index,
  output logic                    pred_ready,
  output logic                    pred_taken,
  input  logic                    res_valid,
  input  logic                    res_taken,
  input  logic                    flush,
  output logic [s_index-1:0]      ctr_read_index,
  input  logic [1:0]              ctr_out,
  output logic [s_index-1:0]      ctr_write_index,
  output logic                    ctr_increment,
  output logic                    ctr_decrement,
  output logic                    ctr_reset,
  output logic                    mispredict,
  output logic                    res_error,
  output logic [$clog2(depth):0]  count
);

  localparam logic [s_index-1:0] LAST_IDX = s_index'(num_sets - 1);

  bp_state_t          state;
  bp_state_t          state_nxt;
  logic [s_index-1:0] sweep;
  logic [s_index-1:0] sweep_nxt;

  logic               push;
  logic               pop;
  logic               err_set;
  logic               fifo_flush;
  logic               fifo_full;
  logic               fifo_empty;
  bp_entry_t          wr_entry;
  bp_entry_t          rd_entry;

  logic [s_index-1:0] upd_index;
  logic               unused_ok;

  // Prediction path is a pure pass-through of the table read port.
  assign ctr_read_index = pred_index;
  assign pred_taken     = ctr_out[1];
  assign wr_entry       = bp_make_entry(BP_IDX_W'(pred_index), ctr_out[1]);
  assign fifo_flush     = (state == RUN) & flush;

  // Counter weak bit and the spare upper index bits of a queue entry are never consumed.
  assign unused_ok = ^{1'b0, ctr_out[0], rd_entry.index[BP_IDX_W-1:s_index]};

  // FSM state and sweep index registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      sweep <= '0;
    end else begin
      state <= state_nxt;
      sweep <= sweep_nxt;
    end
  end

  // Next state, sweep advance, handshake and queue control, all from registered state.
  always_comb begin
    state_nxt       = state;
    sweep_nxt       = sweep;
    ctr_reset       = 1'b0;
    ctr_write_index = upd_index;
    pred_ready      = 1'b0;
    push            = 1'b0;
    pop             = 1'b0;
    err_set         = 1'b0;
    case (state)
      INIT: begin
        ctr_reset       = 1'b1;
        ctr_write_index = sweep;
        sweep_nxt       = sweep + s_index'(1);
        if (sweep == LAST_IDX) state_nxt = RUN;
      end
      RUN: begin
        // Readiness looks only at the registered count: a pop this cycle does not free a slot early.
        pred_ready = ~fifo_full;
        push       = pred_valid & ~fifo_full & ~flush;
        pop        = res_valid & ~fifo_empty & ~flush;
        err_set    = res_valid & fifo_empty & ~flush;
      end
    endcase
  end

  bp_fifo #(
    .W     ($bits(bp_entry_t)),
    .depth (depth)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (fifo_flush),
    .wdat  (wr_entry),
    .rdat  (rd_entry),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Registered training outputs: one pulse per resolved branch, all zero otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_index     <= '0;
      ctr_increment <= 1'b0;
      ctr_decrement <= 1'b0;
      mispredict    <= 1'b0;
      res_error     <= 1'b0;
    end else begin
      upd_index     <= pop ? s_index'(rd_entry.index) : '0;
      ctr_increment <= pop & res_taken;
      ctr_decrement <= pop & ~res_taken;
      mispredict    <= pop & (rd_entry.pred != res_taken);
      res_error     <= err_set;
    end
  end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Self-checking bench for bht_update_ctrl: reference queue model plus update scoreboard.
// Latency: expects training pulses and res_error exactly one cycle after resolution.
// Backpressure: models pred_ready from its own in-flight count.
module tb_bht_update_ctrl;

  localparam int SI    = 3;
  localparam int NS    = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [SI-1:0] idx;
    logic          pred;
  } ent_t;

  typedef struct packed {
    logic [SI-1:0] idx;
    logic          inc;
    logic          dec;
    logic          misp;
  } upd_t;

  logic          clk;
  logic          reset;
  logic          pred_valid;
  logic [SI-1:0] pred_index;
  logic          pred_ready;
  logic          pred_taken;
  logic          res_valid;
  logic          res_taken;
  logic          flush;
  logic [SI-1:0] ctr_read_index;
  logic [1:0]    ctr_out;
  logic [SI-1:0] ctr_write_index;
  logic          ctr_increment;
  logic          ctr_decrement;
  logic          ctr_reset;
  logic          mispredict;
  logic          res_error;
  logic [2:0]    count;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t mq[$];
  upd_t exp_upd[$];
  bit   err_pend = 1'b0;
  bit   mon_en   = 1'b0;

  bht_update_ctrl #(.s_index(SI), .num_sets(NS), .depth(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .pred_valid      (pred_valid),
    .pred_index      (pred_index),
    .pred_ready      (pred_ready),
    .pred_taken      (pred_taken),
    .res_valid       (res_valid),
    .res_taken       (res_taken),
    .flush           (flush),
    .ctr_read_index  (ctr_read_index),
    .ctr_out         (ctr_out),
    .ctr_write_index (ctr_write_index),
    .ctr_increment   (ctr_increment),
    .ctr_decrement   (ctr_decrement),
    .ctr_reset       (ctr_reset),
    .mispredict      (mispredict),
    .res_error       (res_error),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every cycle in RUN the update port must match the queued expectation or be idle.
  always @(negedge clk) begin
    upd_t e;
    if (mon_en) begin
      e = '0;
      if (exp_upd.size() > 0) e = exp_upd.pop_front();
      chk("update_port", 32'({ctr_write_index, ctr_increment, ctr_decrement, mispredict}), 32'(e));
      chk("res_error", 32'(res_error), 32'(err_pend));
      chk("ctr_reset_run", 32'(ctr_reset), 32'd0);
      err_pend = 1'b0;
    end
  end

  // One RUN cycle: drive, check handshake against the model, advance the model at the edge.
  task automatic step(input bit pv, input bit [SI-1:0] pi, input bit [1:0] co,
                      input bit rv, input bit rt, input bit fl);
    bit   rdy_e, do_push, do_pop, do_err;
    ent_t e;
    upd_t u;
    pred_valid = pv; pred_index = pi; ctr_out = co;
    res_valid  = rv; res_taken  = rt; flush   = fl;
    #1;
    rdy_e = (mq.size() < DEPTH);
    chk("pred_ready", 32'(pred_ready), 32'(rdy_e));
    chk("count", 32'(count), 32'(mq.size()));
    chk("ctr_read_index", 32'(ctr_read_index), 32'(pi));
    chk("pred_taken", 32'(pred_taken), 32'(co[1]));
    do_push = pv && rdy_e && !fl;
    do_pop  = rv && (mq.size() > 0) && !fl;
    do_err  = rv && (mq.size() == 0) && !fl;
    u = '0;
    if (do_pop) begin
      e = mq.pop_front();
      u.idx = e.idx; u.inc = rt; u.dec = !rt; u.misp = (e.pred != rt);
    end
    if (do_push) begin
      e.idx = pi; e.pred = co[1];
      mq.push_back(e);
    end
    if (fl) mq.delete();
    @(posedge clk);
    if (do_pop) exp_upd.push_back(u);
    err_pend = do_err;
    #1;
    pred_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
  endtask

  // Post-reset clearing sweep; noise drives the inputs INIT must ignore.
  task automatic sweep(input bit noise);
    for (int i = 0; i < NS; i++) begin
      pred_valid = noise; res_valid = noise; flush = noise && (i % 2 == 1);
      #1;
      chk("sweep_ctr_reset", 32'(ctr_reset), 32'd1);
      chk("sweep_index", 32'(ctr_write_index), 32'(i));
      chk("sweep_ready", 32'(pred_ready), 32'd0);
      chk("sweep_quiet", 32'({ctr_increment, ctr_decrement, mispredict, res_error}), 32'd0);
      @(posedge clk);
      #1;
    end
    pred_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
    #1;
    chk("run_ctr_reset", 32'(ctr_reset), 32'd0);
    chk("run_ready", 32'(pred_ready), 32'd1);
    chk("run_count", 32'(count), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, 32'({mispredict, res_error, ctr_increment, ctr_decrement, ctr_write_index,
                  pred_ready, count}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; pred_valid = 1'b0; pred_index = '0; res_valid = 1'b0;
    res_taken = 1'b0; flush = 1'b0; ctr_out = 2'b00;
    #3;
    chk_reset_outputs("reset_state");
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    sweep(1'b1);
    mon_en = 1'b1;

    // Weakly-taken prediction on index 5 resolved not-taken: decrement plus mispredict.
    step(1'b1, 3'd5, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 2'b00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Correct taken prediction, then not-taken prediction resolved taken.
    step(1'b1, 3'd2, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd7, 2'b01, 1'b1, 1'b1, 1'b0);
    step(1'b0, 3'd0, 2'b00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Fill to depth, then push with resolve at full: pop only.
    for (int k = 0; k < DEPTH; k++) step(1'b1, 3'(k), 2'(k), 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd7, 2'b11, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 3'd0, 2'b00, 1'b1, 1'(k), 1'b0);
    step(1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Resolve with nothing in flight, alone and together with a push.
    step(1'b0, 3'd0, 2'b00, 1'b1, 1'b1, 1'b0);
    step(1'b1, 3'd4, 2'b11, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 2'b00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Flush at count 3 with same-cycle push and resolve.
    step(1'b1, 3'd1, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd2, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd3, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd6, 2'b11, 1'b1, 1'b0, 1'b1);
    step(1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Mixed traffic.
    for (int k = 0; k < 60; k++)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    for (int k = 0; k < DEPTH + 1 && mq.size() > 0; k++)
      step(1'b0, 3'd0, 2'b00, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    step(1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset with two predictions in flight.
    step(1'b1, 3'd1, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd6, 2'b01, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    mq.delete();
    exp_upd.delete();
    err_pend = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    sweep(1'b0);
    mon_en = 1'b1;
    step(1'b1, 3'd3, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 2'b00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("scoreboard_drained", 32'(exp_upd.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bht_update_ctrl.md
BHT_UPDATE_CTRL -- requirements
Module: bht_update_ctrl

Interface
REQ-001 Parameter s_index, default 3: counter-table index width.
REQ-002 Parameter num_sets, default 2**s_index: table entries.
REQ-003 Parameter depth, default 4 (power of 2, ≥2): in-flight prediction queue depth.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 pred_valid  in  1  fetch requests a prediction.
REQ-007 pred_index  in  s_index  table index of the fetched branch.
REQ-008 pred_ready  out  1  prediction request accepted this cycle if pred_valid.
REQ-009 pred_taken  out  1  predicted direction.
REQ-010 res_valid  in  1  oldest in-flight branch resolved (in program order).
REQ-011 res_taken  in  1  actual direction.
REQ-012 flush  in  1  discard all in-flight predictions.
REQ-013 ctr_read_index  out  s_index  counter-table read index.
REQ-014 ctr_out  in  2  counter-table read data.
REQ-015 ctr_write_index, ctr_increment, ctr_decrement, ctr_reset  out  s_index/1/1/1  counter-table update port.
REQ-016 mispredict  out  1  one-cycle pulse, resolved direction ≠ predicted.
REQ-017 res_error  out  1  one-cycle pulse, res_valid with empty queue.
REQ-018 count  out  $clog2(depth)+1  in-flight entries.

Function
REQ-019 FSM states INIT, RUN; reset enters INIT with sweep index 0.
REQ-020 INIT: each cycle drive ctr_reset=1, ctr_write_index=sweep index, increment/decrement=0; sweep index +1; after index num_sets-1 go to RUN (exactly num_sets INIT cycles).
REQ-021 INIT: pred_ready=0; res_valid, flush ignored; res_error not raised.
REQ-022 ctr_read_index = pred_index combinationally; pred_taken = ctr_out[1] combinationally.
REQ-023 pred_ready = (state==RUN) && (count<depth), from registered state only; no same-cycle pop bypass.
REQ-024 Push on pred_valid&&pred_ready: store {pred_index, pred_taken} at tail; tail wraps modulo depth.
REQ-025 Pop on res_valid && count>0 in RUN: remove head entry; head wraps modulo depth.
REQ-026 Cycle after pop: ctr_write_index=entry index, ctr_increment=res_taken, ctr_decrement=!res_taken, mispredict=(entry pred ≠ res_taken); all zero otherwise.
REQ-027 Update outputs registered; ctr_reset=0 and increment/decrement never both 1 in RUN.
REQ-028 Simultaneous push and pop: both occur, count unchanged, legal at count==depth (pop only, pred_ready=0) and count==0 (push only, res_error).
REQ-029 res_valid with count==0: no pop, no update, res_error=1 next cycle.
REQ-030 flush: next cycle count=0, head=tail=0; same-cycle push and pop dropped, no update, no mispredict.
REQ-031 Reads of an index with a pending update see the pre-update value; no forwarding.

Reset
REQ-032 Asynchronous assertion: state=INIT, sweep index=0, head=tail=count=0, mispredict=res_error=ctr_increment=ctr_decrement=0, ctr_write_index=0.
REQ-033 ctr_reset=1 and pred_ready=0 from first cycle after deassertion; reset mid-RUN discards queue and restarts INIT sweep.
REQ-034 Queue storage payload need not be reset.

Structure
REQ-035 Shared package bp_pkg: state enum {INIT,RUN}, queue entry struct {index, pred}.
REQ-036 One sub-module bp_fifo (parameterised sync FIFO with flush) holds queue; FSM and update register logic in top.

Verification
REQ-037 Reset release, s_index=3 -> ctr_reset=1 for exactly 8 cycles, ctr_write_index 0..7, then pred_ready=1.
REQ-038 Push idx 5 with ctr_out=2'b10, resolve not-taken -> next cycle ctr_write_index=5, ctr_decrement=1, mispredict=1.
REQ-039 Push 4 entries, no resolve -> pred_ready=0, count=4; push+resolve same cycle -> pop only, count=3.
REQ-040 res_valid with empty queue -> res_error=1 one cycle, no increment/decrement.
REQ-041 count=3, flush with res_valid and pred_valid -> count=0, no update pulse, mispredict=0.
REQ-042 Reset asserted at count=2 mid-RUN -> outputs zero immediately; full 8-cycle sweep repeats.
